// File: rtl/team_03_arb_pkg.sv
// Shared types and widths for the team_03 Wishbone master arbiter.
package team_03_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/team_03_rr_picker.sv
// Combinational round-robin picker: first requesting index strictly after
// 'last', wrapping modulo N_REQ. Returns a one-hot grant plus its index.
module team_03_rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N_REQ-1:0] gnt_s;
  logic [IDX_W-1:0] idx_s;
  logic             found_s;
  logic             hit_s;
  int               pos_s;

  // Scan the requesters starting just after the previous winner.
  always_comb begin
    gnt_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    pos_s   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      pos_s        = (int'(last_i) + off) % N_REQ;
      hit_s        = req_i[pos_s] & ~found_s;
      gnt_s[pos_s] = gnt_s[pos_s] | hit_s;
      idx_s        = hit_s ? IDX_W'(pos_s) : idx_s;
      found_s      = found_s | hit_s;
    end
  end

  assign gnt_o = gnt_s;
  assign idx_o = idx_s;

endmodule

// File: rtl/team_03_wb_master_arb.sv
// Round-robin arbiter driving one classic single-beat Wishbone master cycle
// per grant, returning read data with a done or timeout-error pulse.
module team_03_wb_master_arb
  import team_03_arb_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk_i,
  input  logic                    nrst,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        we_i,
  input  logic [ADDR_W*N_REQ-1:0] adr_i,
  input  logic [DATA_W*N_REQ-1:0] wdat_i,
  input  logic [SEL_W*N_REQ-1:0]  sel_i,
  output logic [DATA_W-1:0]       rdat_o,
  output logic [N_REQ-1:0]        done_o,
  output logic [N_REQ-1:0]        err_o,
  output logic                    busy_o,
  output logic [ADDR_W-1:0]       ADR_O,
  output logic [DATA_W-1:0]       DAT_O,
  output logic [SEL_W-1:0]        SEL_O,
  output logic                    WE_O,
  output logic                    STB_O,
  output logic                    CYC_O,
  input  logic [DATA_W-1:0]       DAT_I,
  input  logic                    ACK_I
);

  localparam int               IDX_W     = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  last_gnt_q, last_gnt_d;
  logic [N_REQ-1:0]  win_q, win_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic              cyc_q, cyc_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;

  logic [N_REQ-1:0]  pick_gnt_s;
  logic [IDX_W-1:0]  pick_idx_s;

  team_03_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i  (req_i),
    .last_i (last_gnt_q),
    .gnt_o  (pick_gnt_s),
    .idx_o  (pick_idx_s)
  );

  // Next-state logic: grant in IDLE, wait for ACK or timeout in BUS, pulse in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    win_d      = win_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    rdat_d     = rdat_q;
    done_d     = '0;
    err_d      = '0;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d    = BUS;
          cnt_d      = '0;
          win_d      = pick_gnt_s;
          last_gnt_d = pick_idx_s;
          adr_d      = adr_i[ADDR_W*int'(pick_idx_s) +: ADDR_W];
          dat_d      = wdat_i[DATA_W*int'(pick_idx_s) +: DATA_W];
          sel_d      = sel_i[SEL_W*int'(pick_idx_s) +: SEL_W];
          we_d       = we_i[pick_idx_s];
          cyc_d      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        // ACK is checked first so an ACK on the timeout cycle still completes.
        if (ACK_I) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          done_d  = win_q;
          rdat_d  = DAT_I;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          err_d   = win_q;
          rdat_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately.
  always_ff @(posedge clk_i or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= IDX_W'(N_REQ - 1);
      win_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      win_q      <= win_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
    end
  end

  assign ADR_O  = adr_q;
  assign DAT_O  = dat_q;
  assign SEL_O  = sel_q;
  assign WE_O   = we_q;
  assign CYC_O  = cyc_q;
  assign STB_O  = cyc_q;
  assign busy_o = cyc_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign rdat_o = rdat_q;

endmodule
